seven_segment_scanner: RTL and testbench

Parametrised multiplexed seven-segment display driver replacing the fixed 8-digit `select`/`segments` output on the memory-mapped display. Holds a DIGITS-nibble hex value written from the CPU side and scans one digit at a time at a programmable refresh rate. Adds tear-free double buffering, per-digit decimal points, leading-zero blanking, and selectable output polarity and select encoding.

---
 rtl/seven_segment_pkg.sv | 31 +++
 rtl/hex_to_seven_segment.sv | 20 ++
 rtl/seven_segment_scanner.sv | 146 ++++++++++++++
 tb/tb_seven_segment_scanner.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed seven-segment display: glyph table,
// segment bit positions and the select-width rule used by the scanner.
package seven_segment_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high g..a patterns; b and d use the lowercase forms so they differ from 8 and 0.
    localparam logic [6:0] HEX_GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int selectWidth(input int digits, input bit oneHot);
        int width;
        if (oneHot) begin
            return digits;
        end
        width = $clog2(digits);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Combinational decoder from one hex nibble to an active-high glyph with
// optional blanking of g..a; the decimal point passes through untouched.
module hex_to_seven_segment
    import seven_segment_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    input  logic       i_dp,
    output logic [7:0] o_glyph
);

    always_comb begin
        o_glyph = '0;
        if (!i_blank) begin
            o_glyph[SEG_G:SEG_A] = HEX_GLYPHS[i_nibble];
        end
        o_glyph[SEG_DP] = i_dp;
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed hex display driver with a double-buffered value, per-digit
// decimal points, leading-zero blanking and configurable output polarity.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int  DIGITS             = 8,
    parameter int  CLOCK_DIVIDE       = 100000,
    parameter bit  SEGMENT_ACTIVE_LOW = 1'b1,
    parameter bit  SELECT_ONE_HOT     = 1'b0,
    parameter bit  SELECT_ACTIVE_LOW  = 1'b0,
    localparam int SELECT_WIDTH       = selectWidth(DIGITS, SELECT_ONE_HOT)
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [4*DIGITS-1:0]     write_data,
    input  logic [DIGITS-1:0]       dp_mask,
    input  logic                    blank_leading_zeros,
    output logic [SELECT_WIDTH-1:0] select,
    output logic [7:0]              segments,
    output logic                    pending,
    output logic                    frame_start
);

    localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [7:0] SEG_INVERT = SEGMENT_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [SELECT_WIDTH-1:0] SEL_INVERT = {SELECT_WIDTH{SELECT_ACTIVE_LOW}};
    localparam logic [SELECT_WIDTH-1:0] SEL_RESET =
        (SELECT_ONE_HOT ? SELECT_WIDTH'(1) : SELECT_WIDTH'(0)) ^ SEL_INVERT;

    logic [DIV_W-1:0]        r_divider;
    logic [IDX_W-1:0]        r_index;
    logic [4*DIGITS-1:0]     r_shadowData;
    logic [DIGITS-1:0]       r_shadowDp;
    logic                    r_shadowBlank;
    logic [4*DIGITS-1:0]     r_activeData;
    logic [DIGITS-1:0]       r_activeDp;
    logic                    r_activeBlank;
    logic                    r_pending;
    logic                    r_frameStart;
    logic [SELECT_WIDTH-1:0] r_select;
    logic [7:0]              r_segments;

    logic                    w_tick;
    logic                    w_wrap;
    logic [3:0]              w_nibble;
    logic [DIGITS-1:0]       w_zeroFrom;
    logic                    w_blank;
    logic                    w_dp;
    logic [7:0]              w_glyph;
    logic [SELECT_WIDTH-1:0] w_selectCode;

    assign w_tick = (r_divider == DIV_LAST);
    assign w_wrap = w_tick && (r_index == IDX_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_divider <= '0;
            r_index   <= '0;
        end else if (w_tick) begin
            r_divider <= '0;
            r_index   <= w_wrap ? '0 : r_index + 1'b1;
        end else begin
            r_divider <= r_divider + 1'b1;
        end
    end

    // The transfer reads the shadow before this cycle's write lands, so a write
    // colliding with the frame boundary stays pending for the following frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadowData  <= '0;
            r_shadowDp    <= '0;
            r_shadowBlank <= 1'b0;
            r_activeData  <= '0;
            r_activeDp    <= '0;
            r_activeBlank <= 1'b0;
            r_pending     <= 1'b0;
            r_frameStart  <= 1'b0;
        end else begin
            if (write_enable) begin
                r_shadowData  <= write_data;
                r_shadowDp    <= dp_mask;
                r_shadowBlank <= blank_leading_zeros;
            end
            if (w_wrap && r_pending) begin
                r_activeData  <= r_shadowData;
                r_activeDp    <= r_shadowDp;
                r_activeBlank <= r_shadowBlank;
            end
            r_pending    <= write_enable || (r_pending && !w_wrap);
            r_frameStart <= w_wrap;
        end
    end

    // Bit i is set when nibbles i..DIGITS-1 of the displayed value are all zero.
    always_comb begin
        logic allZero;
        allZero    = 1'b1;
        w_zeroFrom = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            allZero       = allZero && (r_activeData[4*i +: 4] == 4'h0);
            w_zeroFrom[i] = allZero;
        end
    end

    assign w_nibble = r_activeData[4*r_index +: 4];
    assign w_blank  = r_activeBlank && (r_index != '0) && w_zeroFrom[r_index];
    assign w_dp     = r_activeDp[r_index];

    hex_to_seven_segment u_decoder (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .i_dp     (w_dp),
        .o_glyph  (w_glyph)
    );

    if (SELECT_ONE_HOT) begin : gOneHot
        always_comb begin
            w_selectCode          = '0;
            w_selectCode[r_index] = 1'b1;
        end
    end else begin : gBinary
        assign w_selectCode = r_index;
    end

    // Select and segments share one register stage so a digit never shows a neighbour's glyph.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_select   <= SEL_RESET;
            r_segments <= SEG_INVERT;
        end else begin
            r_select   <= w_selectCode ^ SEL_INVERT;
            r_segments <= w_glyph ^ SEG_INVERT;
        end
    end

    assign select      = r_select;
    assign segments    = r_segments;
    assign pending     = r_pending;
    assign frame_start = r_frameStart;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: stimulus queues the digits each frame should show and
// monitors pop and compare them as the scanners present new digits.
module tb_seven_segment_scanner;

    logic        clock = 1'b0;
    logic        reset;

    logic        writeEnable;
    logic [31:0] writeData;
    logic [7:0]  dpMask;
    logic        blankLeadingZeros;
    logic [2:0]  select1;
    logic [7:0]  segments1;
    logic        pending1;
    logic        frameStart1;

    logic        writeEnable2;
    logic [15:0] writeData2;
    logic [3:0]  dpMask2;
    logic        blankLeadingZeros2;
    logic [3:0]  select2;
    logic [7:0]  segments2;
    logic        pending2;
    logic        frameStart2;

    typedef struct {
        int         test;
        int         digit;
        logic [7:0] sel;
        logic [7:0] seg;
    } scanEntry_t;

    typedef struct {
        int         step;
        logic [3:0] sel;
        logic       fs;
    } modeEntry_t;

    scanEntry_t scanQueue[$];
    modeEntry_t modeQueue[$];

    int checkCount = 0;
    int failCount  = 0;

    seven_segment_scanner #(
        .DIGITS             (8),
        .CLOCK_DIVIDE       (4),
        .SEGMENT_ACTIVE_LOW (1'b1),
        .SELECT_ONE_HOT     (1'b0),
        .SELECT_ACTIVE_LOW  (1'b0)
    ) dutMain (
        .clock               (clock),
        .reset               (reset),
        .write_enable        (writeEnable),
        .write_data          (writeData),
        .dp_mask             (dpMask),
        .blank_leading_zeros (blankLeadingZeros),
        .select              (select1),
        .segments            (segments1),
        .pending             (pending1),
        .frame_start         (frameStart1)
    );

    seven_segment_scanner #(
        .DIGITS             (4),
        .CLOCK_DIVIDE       (1),
        .SEGMENT_ACTIVE_LOW (1'b1),
        .SELECT_ONE_HOT     (1'b1),
        .SELECT_ACTIVE_LOW  (1'b1)
    ) dutModes (
        .clock               (clock),
        .reset               (reset),
        .write_enable        (writeEnable2),
        .write_data          (writeData2),
        .dp_mask             (dpMask2),
        .blank_leading_zeros (blankLeadingZeros2),
        .select              (select2),
        .segments            (segments2),
        .pending             (pending2),
        .frame_start         (frameStart2)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [7:0] dp, input logic blank);
        writeData         = data;
        dpMask            = dp;
        blankLeadingZeros = blank;
        writeEnable       = 1'b1;
        @(negedge clock);
        writeEnable       = 1'b0;
    endtask

    task automatic waitFrame1(input string name);
        int cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!frameStart1 && cycles < 100);
        checkOutput(name, frameStart1, 1);
    endtask

    task automatic pushFrame1(input int test, input logic [63:0] segBytes);
        @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            scanQueue.push_back('{test, i, 8'(i), segBytes[8*i +: 8]});
        end
    endtask

    task automatic waitDrain1(input string name);
        int cycles = 0;
        while (scanQueue.size() > 0 && cycles < 200) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput(name, scanQueue.size(), 0);
        scanQueue.delete();
    endtask

    // Compares one queued digit each time the main scanner moves to a new select value.
    initial begin
        logic [2:0] prevSel;
        scanEntry_t e;
        prevSel = 3'd0;
        forever begin
            @(negedge clock);
            if (!reset && select1 !== prevSel && scanQueue.size() > 0) begin
                e = scanQueue.pop_front();
                checkOutput($sformatf("t%0d digit%0d select", e.test, e.digit), 32'(select1), 32'(e.sel));
                checkOutput($sformatf("t%0d digit%0d segments", e.test, e.digit), 32'(segments1), 32'(e.seg));
            end
            prevSel = select1;
        end
    end

    // The mode scanner advances every cycle, so one queued entry is checked per cycle.
    initial begin
        modeEntry_t m;
        forever begin
            @(negedge clock);
            if (!reset && modeQueue.size() > 0) begin
                m = modeQueue.pop_front();
                checkOutput($sformatf("modes step%0d select", m.step), 32'(select2), 32'(m.sel));
                checkOutput($sformatf("modes step%0d frame_start", m.step), 32'(frameStart2), 32'(m.fs));
            end
        end
    end

    initial begin
        logic       pendingDropped;
        int         cycles;
        logic [3:0] modeSel [4];

        reset              = 1'b1;
        writeEnable        = 1'b0;
        writeData          = '0;
        dpMask             = '0;
        blankLeadingZeros  = 1'b0;
        writeEnable2       = 1'b0;
        writeData2         = '0;
        dpMask2            = '0;
        blankLeadingZeros2 = 1'b0;

        repeat (3) @(negedge clock);
        checkOutput("power-on segments", segments1, 8'hFF);
        checkOutput("power-on select", select1, 3'd0);
        checkOutput("power-on pending", pending1, 1'b0);
        checkOutput("power-on frame_start", frameStart1, 1'b0);
        reset = 1'b0;

        applyStimulus(32'h12345678, 8'h00, 1'b0);
        checkOutput("pre-reset pending", pending1, 1'b1);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("mid-frame reset segments", segments1, 8'hFF);
        checkOutput("mid-frame reset select", select1, 3'd0);
        checkOutput("mid-frame reset pending", pending1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("release segments", segments1, 8'hFF);
        checkOutput("release select", select1, 3'd0);
        checkOutput("release pending", pending1, 1'b0);
        @(negedge clock);
        checkOutput("post-reset digit0 segments", segments1, 8'hC0);
        checkOutput("post-reset pending", pending1, 1'b0);

        $display("[TB] scan order");
        applyStimulus(32'h89ABCDEF, 8'h00, 1'b0);
        checkOutput("scan pending after write", pending1, 1'b1);
        waitFrame1("scan frame_start");
        checkOutput("scan pending cleared", pending1, 1'b0);
        pushFrame1(1, 64'h80908883C6A1868E);
        waitDrain1("scan drained");

        $display("[TB] double buffer");
        waitFrame1("dbuf old frame_start");
        pushFrame1(2, 64'h80908883C6A1868E);
        repeat (10) @(negedge clock);
        applyStimulus(32'h00000001, 8'h00, 1'b0);
        checkOutput("dbuf pending after write", pending1, 1'b1);
        pendingDropped = 1'b0;
        cycles         = 0;
        do begin
            @(negedge clock);
            cycles++;
            if (!frameStart1 && !pending1) pendingDropped = 1'b1;
        end while (!frameStart1 && cycles < 100);
        checkOutput("dbuf frame_start", frameStart1, 1'b1);
        checkOutput("dbuf pending held to wrap", pendingDropped, 1'b0);
        checkOutput("dbuf pending cleared", pending1, 1'b0);
        pushFrame1(3, 64'hC0C0C0C0C0C0C0F9);
        waitDrain1("dbuf drained");

        $display("[TB] blanking");
        applyStimulus(32'h00000120, 8'h80, 1'b1);
        checkOutput("blank pending after write", pending1, 1'b1);
        waitFrame1("blank frame_start");
        pushFrame1(4, 64'h7FFFFFFFFFF9A4C0);
        waitDrain1("blank drained");
        applyStimulus(32'h00000000, 8'h00, 1'b1);
        waitFrame1("blank zero frame_start");
        pushFrame1(5, 64'hFFFFFFFFFFFFFFC0);
        waitDrain1("blank zero drained");

        $display("[TB] collision");
        waitFrame1("collision sync frame_start");
        for (int c = 1; c <= 31; c++) begin
            @(negedge clock);
            writeEnable       = (c == 5) || (c == 31);
            writeData         = (c == 31) ? 32'h0000000A : 32'h0000000B;
            dpMask            = 8'h00;
            blankLeadingZeros = 1'b0;
        end
        @(negedge clock);
        writeEnable = 1'b0;
        checkOutput("collision frame_start", frameStart1, 1'b1);
        checkOutput("collision pending kept", pending1, 1'b1);
        pushFrame1(6, 64'hC0C0C0C0C0C0C083);
        waitFrame1("collision next frame_start");
        checkOutput("collision pending cleared", pending1, 1'b0);
        pushFrame1(7, 64'hC0C0C0C0C0C0C088);
        waitDrain1("collision drained");

        $display("[TB] one-hot active-low select");
        modeSel[0] = 4'b1110;
        modeSel[1] = 4'b1101;
        modeSel[2] = 4'b1011;
        modeSel[3] = 4'b0111;
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!frameStart2 && cycles < 100);
        checkOutput("modes frame_start", frameStart2, 1'b1);
        checkOutput("modes select at wrap", select2, 4'b0111);
        @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            modeQueue.push_back('{i, modeSel[i % 4], (i % 4) == 3});
        end
        cycles = 0;
        while (modeQueue.size() > 0 && cycles < 50) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput("modes drained", modeQueue.size(), 0);
        modeQueue.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
